// File: rtl/mvm_result_collector.sv
// Captures each K-word MVM result frame into a word FIFO and replays it on a
// valid/ready stream tagged with in-frame index and last. Frames only become visible once complete.
module mvm_result_collector #(
    parameter int K     = 16,
    parameter int B     = 8,
    parameter int DEPTH = 32,
    parameter int LAT   = 1,
    localparam int IW   = (K > 1) ? $clog2(K) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1,
    localparam int WW   = (LAT > 1) ? $clog2(LAT) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mvm_reset,
    input  logic            done,
    input  logic [2*B-1:0]  res_data,
    output logic [2*B-1:0]  m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [IW-1:0]   m_index,
    output logic            m_last,
    output logic            busy,
    output logic [15:0]     frame_count,
    output logic [7:0]      drop_count
);
    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    state_t          state, state_n;
    logic            done_q;
    logic [PW-1:0]   wr_spec, wr_cmt, rd_ptr, rd_next, occ;
    logic [PW:0]     free;
    logic [IW-1:0]   cap_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [2*B-1:0]  mem [DEPTH];
    logic            rise, space_ok, cap_last, wait_last, wr_en, pop;

    assign rise      = done & ~done_q;
    assign occ       = wr_cmt - rd_ptr;
    assign free      = (PW+1)'(DEPTH) - {1'b0, occ};
    assign space_ok  = free >= (PW+1)'(K);
    assign cap_last  = cap_cnt == IW'(K - 1);
    assign wait_last = wait_cnt == WW'((LAT > 1) ? LAT - 2 : 0);
    assign wr_en     = (state == CAPTURE) && !mvm_reset;
    assign m_valid   = wr_cmt != rd_ptr;
    assign pop       = m_valid && m_ready;
    assign rd_next   = rd_ptr + (pop ? PW'(1) : PW'(0));
    assign m_last    = m_index == IW'(K - 1);
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rise && space_ok) state_n = (LAT == 1) ? CAPTURE : WAIT;
            WAIT:    if (mvm_reset) state_n = IDLE;
                     else if (wait_last) state_n = CAPTURE;
            CAPTURE: if (mvm_reset || cap_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_spec[AW-1:0]] <= res_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q      <= 1'b0;
            wr_spec     <= '0;
            wr_cmt      <= '0;
            rd_ptr      <= '0;
            cap_cnt     <= '0;
            wait_cnt    <= '0;
            m_data      <= '0;
            m_index     <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            done_q <= done;
            if (state == IDLE && rise && !space_ok && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            wait_cnt <= (state == WAIT) ? wait_cnt + WW'(1) : '0;
            // Abort rolls the speculative pointer back; committed words stay intact
            if (busy && mvm_reset) begin
                wr_spec <= wr_cmt;
                cap_cnt <= '0;
            end else if (state == CAPTURE) begin
                wr_spec <= wr_spec + PW'(1);
                cap_cnt <= cap_last ? '0 : cap_cnt + IW'(1);
                if (cap_last) begin
                    wr_cmt      <= wr_spec + PW'(1);
                    frame_count <= frame_count + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr  <= rd_next;
                m_index <= m_last ? '0 : m_index + IW'(1);
            end
            // Show-ahead register; bypass covers a write landing on the next read slot
            m_data <= (wr_en && wr_spec[AW-1:0] == rd_next[AW-1:0]) ? res_data
                                                                   : mem[rd_next[AW-1:0]];
        end
    end
endmodule

// File: tb/tb_mvm_result_collector.sv
// Randomized scenario bench for mvm_result_collector (K=4, DEPTH=8, LAT=1) with a
// queue-based model of committed frames and a monitor that scores every popped word.
module tb_mvm_result_collector;
    localparam int K = 4, B = 8, DEPTH = 8, LAT = 1;

    logic        clk, reset, mvm_reset, done, m_ready;
    logic [15:0] res_data, m_data;
    logic        m_valid, m_last, busy;
    logic [1:0]  m_index;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;

    mvm_result_collector #(.K(K), .B(B), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .mvm_reset(mvm_reset), .done(done),
        .res_data(res_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_index(m_index), .m_last(m_last), .busy(busy),
        .frame_count(frame_count), .drop_count(drop_count));

    int          n_tests = 0, n_fail = 0;
    int          exp_frames = 0, exp_drops = 0, mon_idx = 0, mon_count = 0;
    logic [15:0] exp_q[$];
    logic [15:0] fr[4];
    bit          toggle_en = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) if (toggle_en) begin
        #1;
        m_ready = ~m_ready;
    end

    // Scoreboard: every accepted word must be the oldest committed one
    always @(negedge clk) if (!reset && m_valid) begin
        if (m_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_word: got data=%h, required no word", m_data);
            end else begin
                if (m_data !== exp_q[0] || m_index !== 2'(mon_idx) || m_last !== (mon_idx == K-1)) begin
                    n_fail++;
                    $display("FAIL word_%0d: got data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                             mon_count, m_data, m_index, m_last, exp_q[0], mon_idx, mon_idx == K-1);
                end
                void'(exp_q.pop_front());
                mon_idx = (mon_idx + 1) % K;
                mon_count++;
            end
        end else if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_valid: got m_valid=1, required 0");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1; done = 0; mvm_reset = 0; res_data = '0; m_ready = 0; toggle_en = 0;
        tick(); tick();
        exp_q.delete();
        mon_idx = 0; exp_frames = 0; exp_drops = 0;
        reset = 0;
        tick();
    endtask

    task automatic rand_frame();
        for (int i = 0; i < K; i++) fr[i] = 16'($urandom);
    endtask

    task automatic push_frame();
        for (int i = 0; i < K; i++) exp_q.push_back(fr[i]);
        exp_frames++;
    endtask

    // One done pulse followed by K words; abort_at >= 0 pulses mvm_reset after that many captures
    task automatic send_frame(input bit acc, input int abort_at);
        done = 1;
        tick();
        done = 0;
        for (int i = 0; i < K; i++) begin
            if (i == abort_at) begin
                mvm_reset = 1;
                tick();
                mvm_reset = 0;
                return;
            end
            res_data = fr[i];
            tick();
        end
        if (acc) push_frame();
        else if (exp_drops < 255) exp_drops++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d words left, required 0", name, exp_q.size());
        end
        tick(); tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_empty: got m_valid=%b, required 0", name, m_valid);
        end
    endtask

    task automatic check_counts(input string name);
        n_tests++;
        if (frame_count !== 16'(exp_frames) || drop_count !== 8'(exp_drops)) begin
            n_fail++;
            $display("FAIL %s_counts: got frames=%0d drops=%0d, required frames=%0d drops=%0d",
                     name, frame_count, drop_count, exp_frames, exp_drops);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({m_data, m_valid, m_index, m_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_stream: got data=%h valid=%b idx=%0d last=%b, required all 0",
                     m_data, m_valid, m_index, m_last);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        check_counts("reset");
    endtask

    task automatic test_single();
        apply_reset();
        m_ready = 1;
        fr[0] = 16'hFFFD; fr[1] = 16'd7; fr[2] = 16'd100; fr[3] = 16'h8000;
        send_frame(1, -1);
        drain("single");
        check_counts("single");
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame(DEPTH - exp_q.size() >= K, -1);
        end
        tick();
        n_tests++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stalled_valid: got %b, required 1", m_valid);
        end
        check_counts("bp_stalled");
        m_ready = 1;
        drain("bp");
        check_counts("bp");
    endtask

    task automatic test_abort();
        apply_reset();
        m_ready = 1;
        rand_frame();
        send_frame(1, 2);
        repeat (5) tick();
        n_tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got valid=%b busy=%b, required 0 0", m_valid, busy);
        end
        check_counts("abort");
        for (int i = 0; i < K; i++) fr[i] = 16'(i + 1);
        send_frame(1, -1);
        drain("abort_next");
        check_counts("abort_next");
    endtask

    task automatic test_retrigger();
        apply_reset();
        m_ready = 1;
        rand_frame();
        done = 1;
        tick();
        res_data = fr[0];
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL retrig_busy: got %b, required 1", busy);
        end
        done = 0; res_data = fr[1];
        tick();
        done = 1; res_data = fr[2];
        tick();
        res_data = fr[3];
        tick();
        push_frame();
        repeat (10) tick();
        done = 0;
        drain("retrig");
        check_counts("retrig");
    endtask

    task automatic test_wrap();
        int start_count, n;
        apply_reset();
        start_count = mon_count;
        toggle_en = 1;
        for (int f = 0; f < 20; f++) begin
            n = 0;
            while (exp_q.size() > DEPTH - K - 1 && n < 200) begin
                tick();
                n++;
            end
            rand_frame();
            send_frame(1, -1);
        end
        toggle_en = 0;
        tick();
        m_ready = 1;
        drain("wrap");
        check_counts("wrap");
        n_tests++;
        if (mon_count - start_count != 20 * K) begin
            n_fail++;
            $display("FAIL wrap_words: got %0d words, required %0d", mon_count - start_count, 20 * K);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        rand_frame();
        send_frame(1, -1);
        n_tests++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pending: got m_valid=%b, required 1", m_valid);
        end
        done = 1;
        tick();
        done = 0; res_data = 16'($urandom);
        tick(); tick();
        #2;
        reset = 1;
        exp_q.delete();
        exp_frames = 0; exp_drops = 0; mon_idx = 0;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_index !== 2'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got valid=%b busy=%b idx=%0d, required 0 0 0",
                     m_valid, busy, m_index);
        end
        check_counts("areset");
        tick();
        reset = 0;
        m_ready = 1;
        repeat (4) tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_after: got m_valid=%b, required 0", m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_abort();
        test_retrigger();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mvm_result_collector.md
Name: mvm_result_collector

Overview:
- Consumer for the result stream of the matrix-vector multiplier.
- After `done` rises, the MVM presents K signed 2B-bit results on consecutive cycles. This block captures each complete frame into a word FIFO and re-issues it on a valid/ready stream with index and last tags.
- Sits between the MVM `data_out`/`done` pins and downstream logic (host readback or the next compute stage), so results are no longer lost when the consumer stalls.

Parameters:
- K, 16: results per frame (matrix dimension).
- B, 8: MVM input width; result width is 2*B.
- DEPTH, 32: FIFO depth in words; power of 2, at least K.
- LAT, 1: cycles from the edge where `done` is first sampled high to the edge capturing y[0]; at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- mvm_reset  in  1  synchronous; mirrors the MVM reset line and aborts the frame in progress
- done  in  1  MVM done; only a rising edge is significant
- res_data  in  2B  MVM data_out, signed
- m_data  out  2B  output result word
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- m_index  out  clog2(K)  position of m_data within its frame, 0..K-1
- m_last  out  1  high with index K-1
- busy  out  1  high in WAIT or CAPTURE
- frame_count  out  16  committed frames; wraps modulo 2^16
- drop_count  out  8  dropped frames; saturates at 255

Behaviour:
- Reset values: all outputs 0. FIFO empty, state IDLE, all pointers 0.
- Rising-edge detect: a registered copy of `done`. The previous-`done` register clears on reset.
- States and transitions:
  - IDLE: on a `done` rise, check free space (DEPTH minus committed occupancy, computed at that edge).
    - If free is at least K: go to WAIT, or straight to CAPTURE when LAT=1.
    - Otherwise: drop the frame, drop_count+1 (saturating), stay in IDLE.
  - WAIT: count LAT-1 cycles, then go to CAPTURE.
  - CAPTURE: write res_data at the speculative write pointer on each of K consecutive edges; the capture counter runs 0..K-1.
    - After the K-th write, publish the speculative pointer to the committed pointer, frame_count+1, go to IDLE.
- Timing with LAT=1: `done` sampled high at edge E0; y[i] captured at edge E(1+i); committed at E(K). The first word can show m_valid at E(K)+0, i.e. in the cycle after the commit edge.
- Read side:
  - Sees only committed words: m_valid = (committed write pointer != read pointer).
  - m_data is registered from FIFO storage (show-ahead).
  - The word pops on m_valid && m_ready.
  - m_index is a read-side counter: +1 per pop, back to 0 after K-1; m_last = (m_index == K-1).
- Read and write may occur in the same cycle; occupancy is computed from committed pointers, so a pop during CAPTURE frees space only for later frames.
- Pointers are clog2(DEPTH)+1 bits and wrap naturally; full means MSBs differ with the lower bits equal.
- `done` edges while in WAIT or CAPTURE are ignored and not counted as drops. Another `done` rise on the commit edge is also ignored. `done` held high does not retrigger.
- mvm_reset high in WAIT or CAPTURE:
  - Roll the speculative pointer back to the committed pointer, go to IDLE. No count changes.
  - The edge-detect register updates normally.
- mvm_reset in IDLE has no effect. Committed data and the read side are never affected by mvm_reset.
- Async reset mid-frame clears everything, including committed data.
- res_data is captured verbatim; no sign extension or arithmetic is applied.

Test Plan:
- Single frame, K=4, DEPTH=8, m_ready=1: `done` rise, then res_data -3,7,100,-32768 on E1..E4 -> m_data -3,7,100,-32768 with m_index 0..3, m_last only on the 4th word, frame_count=1.
- Backpressure, K=4, DEPTH=8, m_ready=0: send frames A and B, then a third `done` rise -> third frame dropped, drop_count=1. With m_ready=1, A then B are output in order, frame_count=2.
- Abort: mvm_reset asserted after 2 of 4 captures -> no m_valid, frame_count=0. The next full frame 1,2,3,4 is output as 1,2,3,4 with m_index starting at 0.
- Retrigger and hold: `done` held high 10 cycles, plus a second rise during CAPTURE -> exactly one frame committed, drop_count=0.
- Wrap: with DEPTH=8, K=4, pass 20 frames with m_ready toggling every cycle -> all 80 words in order, frame_count=20, no drops.
- Async reset with 4 committed words pending -> m_valid=0, counts 0, busy=0, all immediately.
